// File: rtl/onehot_encoder_8x3_seq_pkg.sv
// rtl/onehot_encoder_8x3_seq_pkg.sv - shared types, constants and popcount for the 8-to-3 sequential encoder
package onehot_encoder_8x3_seq_pkg;

   typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

   localparam int N_IN   = 8;
   localparam int W_CODE = 3;
   localparam int W_CNT  = 4;

   function automatic logic [3:0] popcount8(input logic [7:0] vec);
      logic [3:0] sum;
      sum = '0;
      for (int i = 0; i < 8; i++) begin
         sum = sum + {3'b000, vec[i]};
      end
      return sum;
   endfunction

endpackage

// File: rtl/onehot_encoder_8x3_seq_lsb_pick_8.sv
// rtl/onehot_encoder_8x3_seq_lsb_pick_8.sv - lowest-set-bit finder: index, one-hot mask, single-bit flag
module lsb_pick_8
   import onehot_encoder_8x3_seq_pkg::*;
(
   input  logic [7:0]        vec,
   output logic [W_CODE-1:0] idx,
   output logic [7:0]        mask,
   output logic              single
);

   // Scan from the top so the last hit wins, leaving the lowest set bit.
   always_comb begin
      idx = '0;
      for (int i = 7; i >= 0; i--) begin
         if (vec[i]) begin
            idx = W_CODE'(i);
         end
      end
   end

   assign mask   = vec & (~vec + 8'd1);
   assign single = (vec != 8'd0) && ((vec & (vec - 8'd1)) == 8'd0);

endmodule

// File: rtl/onehot_encoder_8x3_seq.sv
// rtl/onehot_encoder_8x3_seq.sv - sequential 8-to-3 encoder emitting one code per set request bit
module onehot_encoder_8x3_seq
   import onehot_encoder_8x3_seq_pkg::*;
#(
   parameter int N_IN  = 8,
   parameter int W_CNT = 4
)
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [0:7]       R,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             A,
   output logic             B,
   output logic             C,
   output logic             out_last,
   output logic [W_CNT-1:0] count,
   output logic             zero_err
);

   if (N_IN != 8) begin : g_bad_width
      $error("onehot_encoder_8x3_seq supports only N_IN == 8");
   end

   state_t            state, state_nxt;
   logic [7:0]        req, pending, pending_nxt, pick_mask;
   logic [W_CODE-1:0] pick_idx;
   logic              pick_single;
   logic [W_CNT-1:0]  count_nxt;
   logic              zero_err_nxt;
   logic              accept, fire;

   // Re-index the ascending request port so req[i] is request i.
   always_comb begin
      req = '0;
      for (int i = 0; i < 8; i++) begin
         req[i] = R[i];
      end
   end

   lsb_pick_8 u_pick (
      .vec    (pending),
      .idx    (pick_idx),
      .mask   (pick_mask),
      .single (pick_single)
   );

   assign out_valid = (state == BUSY);
   assign out_last  = out_valid & pick_single;
   assign A         = out_valid & pick_idx[2];
   assign B         = out_valid & pick_idx[1];
   assign C         = out_valid & pick_idx[0];
   assign in_ready  = rst_n & ((state == IDLE) | (out_last & out_ready));
   assign accept    = in_valid & in_ready;
   assign fire      = out_valid & out_ready;

   always_comb begin
      state_nxt    = state;
      pending_nxt  = pending;
      count_nxt    = count;
      zero_err_nxt = 1'b0;
      if (fire) begin
         pending_nxt = pending & ~pick_mask;
         if (out_last) begin
            state_nxt = IDLE;
         end
      end
      // A new vector on the last beat overrides the drain to IDLE.
      if (accept) begin
         if (req == 8'd0) begin
            zero_err_nxt = 1'b1;
         end else begin
            pending_nxt = req;
            count_nxt   = W_CNT'(popcount8(req));
            state_nxt   = BUSY;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         pending  <= '0;
         count    <= '0;
         zero_err <= 1'b0;
      end else begin
         state    <= state_nxt;
         pending  <= pending_nxt;
         count    <= count_nxt;
         zero_err <= zero_err_nxt;
      end
   end

endmodule

// File: tb/tb_onehot_encoder_8x3_seq.sv
// tb/tb_onehot_encoder_8x3_seq.sv - directed self-checking bench for onehot_encoder_8x3_seq
module tb_onehot_encoder_8x3_seq;

   logic       clk = 1'b0;
   logic       rst_n, in_valid, in_ready, out_valid, out_ready;
   logic [0:7] R;
   logic       A, B, C, out_last, zero_err;
   logic [3:0] count;
   logic [2:0] abc;
   int         n_tests = 0;
   int         n_fail  = 0;

   assign abc = {A, B, C};

   always #5 clk = ~clk;

   onehot_encoder_8x3_seq #(.N_IN(8), .W_CNT(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .R         (R),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .A         (A),
      .B         (B),
      .C         (C),
      .out_last  (out_last),
      .count     (count),
      .zero_err  (zero_err)
   );

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   // Present a vector for one cycle in IDLE; it must be accepted.
   task automatic send(input logic [0:7] r);
      in_valid = 1'b1;
      R        = r;
      #1;
      check("send_in_ready", in_ready, 1);
      step();
      in_valid = 1'b0;
      R        = '0;
   endtask

   // One accepted output beat with out_ready high.
   task automatic beat(input string tag, input logic [2:0] code, input logic last);
      out_ready = 1'b1;
      #1;
      check({tag, "_valid"}, out_valid, 1);
      check({tag, "_code"}, abc, code);
      check({tag, "_last"}, out_last, last);
      check({tag, "_in_ready"}, in_ready, last);
      step();
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; R = '0;
      step();
      check("rst_out_valid", out_valid, 0);
      check("rst_in_ready", in_ready, 0);
      check("rst_count", count, 0);
      check("rst_zero_err", zero_err, 0);
      check("rst_abc", abc, 0);
      check("rst_last", out_last, 0);
      rst_n = 1'b1;
      #1;
      check("idle_in_ready", in_ready, 1);
      step();

      // Single bit R[2].
      out_ready = 1'b1;
      send(8'b0010_0000);
      check("single_count", count, 1);
      beat("single", 3'd2, 1'b1);
      check("single_after_valid", out_valid, 0);

      // R[1], R[4], R[7].
      send(8'b0100_1001);
      check("three_count", count, 3);
      beat("three_b0", 3'd1, 1'b0);
      beat("three_b1", 3'd4, 1'b0);
      beat("three_b2", 3'd7, 1'b1);
      check("three_after_valid", out_valid, 0);

      // Same vector with backpressure on the first beat.
      out_ready = 1'b0;
      send(8'b0100_1001);
      for (int i = 0; i < 3; i++) begin
         check("bp_valid", out_valid, 1);
         check("bp_code", abc, 1);
         check("bp_last", out_last, 0);
         check("bp_in_ready", in_ready, 0);
         step();
      end
      beat("bp_b0", 3'd1, 1'b0);
      beat("bp_b1", 3'd4, 1'b0);
      beat("bp_b2", 3'd7, 1'b1);

      // All-zero vector.
      send(8'b0000_0000);
      check("zero_pulse", zero_err, 1);
      check("zero_valid", out_valid, 0);
      check("zero_count", count, 3);
      step();
      check("zero_pulse_end", zero_err, 0);
      check("zero_valid2", out_valid, 0);

      // 0xFF then R[5] back-to-back.
      send(8'hFF);
      check("ff_count", count, 8);
      for (int i = 0; i < 7; i++) begin
         beat("ff", 3'(i), 1'b0);
      end
      in_valid = 1'b1;
      R        = 8'b0000_0100;
      beat("ff_b7", 3'd7, 1'b1);
      in_valid = 1'b0;
      R        = '0;
      check("b2b_count", count, 1);
      beat("b2b", 3'd5, 1'b1);
      check("b2b_after_valid", out_valid, 0);

      // Asynchronous reset during beat 2 of 3.
      send(8'b0100_1001);
      beat("rst_b0", 3'd1, 1'b0);
      out_ready = 1'b1;
      #1;
      check("rst_b1_code", abc, 4);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_valid", out_valid, 0);
      check("async_in_ready", in_ready, 0);
      step();
      rst_n = 1'b1;
      #1;
      check("post_rst_in_ready", in_ready, 1);
      check("post_rst_count", count, 0);
      for (int i = 0; i < 3; i++) begin
         check("post_rst_valid", out_valid, 0);
         step();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
